// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_pkg : shared types, mode encodings and bit helpers for arbiter_n_m     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package arb_pkg;

  localparam int unsigned ARB_MAX_N = 32;
  localparam int unsigned ARB_IDX_W = 5;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

  typedef logic [ARB_MAX_N-1:0] arb_vec_t;

  // Rotate the low n bits of v right by sh, so bit sh lands at position 0.
  function automatic arb_vec_t arb_rotr(input arb_vec_t v, input int unsigned sh,
                                        input int unsigned n);
    arb_vec_t r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (i < n) begin
        k = (i + sh) % n;
        r[i[ARB_IDX_W-1:0]] = v[k[ARB_IDX_W-1:0]];
      end
    end
    return r;
  endfunction

  function automatic int unsigned arb_first_set(input arb_vec_t v);
    int unsigned pos;
    pos = ARB_MAX_N;
    for (int i = ARB_MAX_N - 1; i >= 0; i--) begin
      if (v[i[ARB_IDX_W-1:0]]) pos = unsigned'(i);
    end
    return pos;
  endfunction

  function automatic int unsigned arb_popcount(input arb_vec_t v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (v[i[ARB_IDX_W-1:0]]) c++;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbiter_n_m_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arbiter_n_m_if : request/grant bundle between requesters and arbiter_n_m   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface arbiter_n_m_if #(
  parameter int N_REQ = 5,
  parameter int N_GNT = 2
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(N_GNT + 1);

  logic [N_REQ-1:0] req_in;
  logic             valid;
  logic             mode_fixed;
  logic [N_REQ-1:0] grant_out;
  logic             gnt_valid;
  logic [CNT_W-1:0] gnt_count;
  logic [PTR_W-1:0] ptr_out;

  modport master (
    output req_in, valid, mode_fixed,
    input  grant_out, gnt_valid, gnt_count, ptr_out
  );

  modport slave (
    input  req_in, valid, mode_fixed,
    output grant_out, gnt_valid, gnt_count, ptr_out
  );
endinterface
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_rr_pick : first set request at or after i_start, wrapping modulo N_REQ |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter  int N_REQ = 5,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_start,
  output logic [N_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_found
);

  arb_vec_t w_rot;

  // Rotating by the start index turns the wrapped scan into a lowest-bit search.
  always_comb begin
    w_rot    = arb_rotr(arb_vec_t'(i_req), 32'(i_start), N_REQ);
    o_found  = (w_rot != '0);
    o_idx    = i_start;
    o_onehot = '0;
    if (o_found) begin
      o_idx    = PTR_W'((32'(i_start) + arb_first_set(w_rot)) % N_REQ);
      o_onehot = N_REQ'(1) << o_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbiter_n_m.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arbiter_n_m : N-request / M-grant round-robin or fixed-priority arbiter    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module arbiter_n_m
  import arb_pkg::*;
#(
  parameter int N_REQ = 5,
  parameter int N_GNT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  arbiter_n_m_if.slave  bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(N_GNT + 1);

  logic [N_GNT-1:0][N_REQ-1:0] w_req;
  logic [N_GNT-1:0][N_REQ-1:0] w_hot;
  logic [N_GNT-1:0][N_REQ-1:0] w_acc;
  logic [N_GNT-1:0][PTR_W-1:0] w_start;
  logic [N_GNT-1:0][PTR_W-1:0] w_idx;
  logic [N_GNT-1:0][PTR_W-1:0] w_nxt;
  logic [N_GNT-1:0]            w_found;

  logic [PTR_W-1:0] w_start0;
  logic [N_REQ-1:0] w_grant;
  logic [CNT_W-1:0] w_count;
  logic             w_rr;

  logic [N_REQ-1:0] r_grant;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic [PTR_W-1:0] r_ptr;

  assign w_rr     = (bus.mode_fixed == ARB_MODE_RR);
  assign w_start0 = w_rr ? r_ptr : '0;

  // Each stage removes its winner and resumes the scan just past it; a stage
  // that finds nothing passes its start through so w_nxt tracks the last winner.
  for (genvar g = 0; g < N_GNT; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign w_req[g]   = bus.req_in;
      assign w_start[g] = w_start0;
      assign w_acc[g]   = w_hot[g];
    end else begin : g_next
      assign w_req[g]   = w_req[g-1] & ~w_hot[g-1];
      assign w_start[g] = w_nxt[g-1];
      assign w_acc[g]   = w_acc[g-1] | w_hot[g];
    end

    arb_rr_pick #(
      .N_REQ (N_REQ)
    ) u_pick (
      .i_req    (w_req[g]),
      .i_start  (w_start[g]),
      .o_onehot (w_hot[g]),
      .o_idx    (w_idx[g]),
      .o_found  (w_found[g])
    );

    assign w_nxt[g] = !w_found[g]                    ? w_start[g] :
                      (w_idx[g] == PTR_W'(N_REQ - 1)) ? '0         :
                                                        w_idx[g] + PTR_W'(1);
  end

  assign w_grant = w_acc[N_GNT-1];
  assign w_count = CNT_W'(arb_popcount(arb_vec_t'(w_grant)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (bus.valid) begin
      r_grant <= w_grant;
      r_count <= w_count;
      r_valid <= |w_grant;
      if (w_rr && |w_grant) begin
        r_ptr <= w_nxt[N_GNT-1];
      end
    end else begin
      r_grant <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end
  end

  assign bus.grant_out = r_grant;
  assign bus.gnt_count = r_count;
  assign bus.gnt_valid = r_valid;
  assign bus.ptr_out   = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_n_m.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arbiter_n_m : vector table, corner sequences and random model checks    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_arbiter_n_m;

  localparam int N = 5;
  localparam int G = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  arbiter_n_m_if #(.N_REQ(N), .N_GNT(G)) bus ();

  arbiter_n_m #(.N_REQ(N), .N_GNT(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    bit         v;
    bit         fx;
    logic [4:0] req;
    logic [4:0] eg;
    int         ep;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ptr = 0;
  int   wait_cnt[N];

  task automatic cmp(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] eg, input int ep);
    cmp({tag, " grant"},        int'(bus.grant_out), int'(eg));
    cmp({tag, " count"},        int'(bus.gnt_count), $countones(eg));
    cmp({tag, " valid"},        int'(bus.gnt_valid), int'(eg != '0));
    cmp({tag, " ptr"},          int'(bus.ptr_out),   ep);
    cmp({tag, " count_vs_pop"}, int'(bus.gnt_count), $countones(bus.grant_out));
  endtask

  task automatic drive(input bit v, input bit fx, input logic [N-1:0] req);
    bus.valid      = v;
    bus.mode_fixed = fx;
    bus.req_in     = req;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all("reset", '0, 0);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Reference: walk requesters from the scan start, take the first G requesting.
  task automatic model_step(input bit v, input bit fx, input logic [N-1:0] req,
                            output logic [N-1:0] eg);
    int start;
    int taken;
    int last;
    eg = '0;
    if (v) begin
      start = fx ? 0 : m_ptr;
      taken = 0;
      last  = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (start + k) % N;
        if (req[i] && taken < G) begin
          eg[i] = 1'b1;
          taken++;
          last = i;
        end
      end
      if (!fx && last >= 0) m_ptr = (last + 1) % N;
    end
  endtask

  // A continuously requesting port must be granted within ceil(N/G)=3 RR cycles.
  task automatic fairness(input bit v, input bit fx, input logic [N-1:0] req);
    int worst;
    worst = 0;
    for (int i = 0; i < N; i++) begin
      if (!req[i] || (v && bus.grant_out[i])) wait_cnt[i] = 0;
      else if (v && !fx) wait_cnt[i]++;
      if (wait_cnt[i] > worst) worst = wait_cnt[i];
    end
    if (v && !fx) begin
      n_vec++;
      if (worst > 2) begin
        n_err++;
        $display("FAIL fairness: waited %0d cycles, limit 2 misses", worst);
      end
    end
  endtask

  initial begin
    logic [N-1:0] eg;
    bit           v;
    bit           fx;
    logic [N-1:0] req;

    // Reset, then unqualified requests must leave everything idle.
    apply_reset();
    drive(1'b0, 1'b0, 5'h1f);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all("idle_after_reset", '0, 0);
    end

    tbl.push_back('{1'b1, 1'b1, 1'b0, 5'h1a, 5'h0a, 4});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5'h1a, 5'h12, 2});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 5'h1f, 5'h03, 2});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5'h1f, 5'h0c, 4});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5'h1f, 5'h11, 1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5'h1f, 5'h06, 3});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5'h04, 5'h04, 3});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5'h00, 5'h00, 3});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 5'h1f, 5'h00, 3});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 5'h1f, 5'h03, 3});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 5'h1f, 5'h03, 3});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 5'h1f, 5'h03, 3});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5'h1f, 5'h18, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5'h1f, 5'h03, 2});

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) apply_reset();
      drive(tbl[i].v, tbl[i].fx, tbl[i].req);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].eg, tbl[i].ep);
    end

    // Asynchronous reset asserted between edges mid-scan.
    apply_reset();
    drive(1'b1, 1'b0, 5'h1f);
    @(posedge clk);
    #1;
    check_all("midrst pre1", 5'h03, 2);
    @(posedge clk);
    #1;
    check_all("midrst pre2", 5'h0c, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midrst async", '0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("midrst first", 5'h03, 2);

    // Randomized traffic against the reference model.
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(9, 0) != 0);
      fx  = ($urandom_range(4, 0) == 0);
      req = (c % 50 < 20) ? 5'h1f : N'($urandom);
      drive(v, fx, req);
      model_step(v, fx, req, eg);
      @(posedge clk);
      #1;
      check_all("rand", eg, m_ptr);
      fairness(v, fx, req);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
